// File: rtl/bias_add_1.sv
// bias_add_1: per-channel bias addition for the layer-1 output stream.
// Each frame first loads N_CH bias coefficients, then streams N_PIX pixels of
// channel-interleaved accumulators. Each accumulator gets its channel's bias,
// then round-half-up, arithmetic right shift, optional ReLU and saturation.
// One result register drains into the downstream FIFO.
module bias_add_1 #(
  parameter int N_CH    = 16,
  parameter int N_PIX   = 784,
  parameter int ACC_W   = 32,
  parameter int COEFF_W = 16,
  parameter int DATA_W  = 16,
  parameter int SHIFT   = 8,
  parameter int RELU    = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [DATA_W-1:0]  output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int CH_W  = (N_CH  > 1) ? $clog2(N_CH)  : 1;
  localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Rounding offset: half of one output LSB at accumulator scale.
  localparam logic signed [ACC_W+1:0] HALF = (ACC_W+2)'(1) << (SHIFT - 1);
  // Output range expressed at the widened sum width.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic [0:0]                state;
  logic [CH_W-1:0]           ld_cnt;
  logic [CH_W-1:0]           ch;
  logic [PIX_W-1:0]          pix;
  logic signed [COEFF_W-1:0] bias_mem [N_CH];
  logic signed [DATA_W-1:0]  out_q;
  logic                      out_vld;

  logic                      accept;
  logic signed [DATA_W-1:0]  result;

  // Sign-extend both operands one bit past the accumulator so the sum never wraps.
  function automatic logic signed [ACC_W:0] add_bias(
    input logic signed [ACC_W-1:0]   acc,
    input logic signed [COEFF_W-1:0] b
  );
    logic signed [ACC_W:0] a_x;
    logic signed [ACC_W:0] b_x;
    a_x = {acc[ACC_W-1], acc};
    b_x = {{(ACC_W+1-COEFF_W){b[COEFF_W-1]}}, b};
    return a_x + b_x;
  endfunction

  // Round half up, then drop SHIFT fraction bits with an arithmetic shift.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W:0] s);
    logic signed [ACC_W+1:0] t;
    t = {s[ACC_W], s} + HALF;
    t = t >>> SHIFT;
    return t[ACC_W:0];
  endfunction

  // Optional rectifier on the rounded value.
  function automatic logic signed [ACC_W:0] relu_clamp(input logic signed [ACC_W:0] r);
    if (RELU != 0 && r < 0) return '0;
    return r;
  endfunction

  // Clip to the signed output range.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W:0] r);
    if (r > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (r < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return r[DATA_W-1:0];
  endfunction

  assign bias_V_read    = (state == LOAD) & bias_V_empty_n;
  assign accept         = (state == RUN) & input_V_empty_n & (~out_vld | output_V_full_n);
  assign input_V_read   = accept;
  assign output_V_write = out_vld & output_V_full_n;
  assign output_V_din   = out_q;

  assign result = saturate(relu_clamp(round_shift(
                    add_bias($signed(input_V_dout), bias_mem[ch]))));

  // Bias bank: written in LOAD only, read from the registered copy in RUN.
  always_ff @(posedge ap_clk) begin
    if (bias_V_read) bias_mem[ld_cnt] <= $signed(bias_V_dout);
  end

  // Frame sequencing: bias load, then N_PIX x N_CH accumulators, then reload.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= LOAD;
      ld_cnt <= '0;
      ch     <= '0;
      pix    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bias_V_read) begin
            if (ld_cnt == CH_LAST) begin
              ld_cnt <= '0;
              state  <= RUN;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            if (ch == CH_LAST) begin
              ch <= '0;
              if (pix == PIX_LAST) begin
                pix   <= '0;
                state <= LOAD;
              end else begin
                pix <= pix + 1'b1;
              end
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output register: load on accept, hold under backpressure, free on write.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      if (accept) begin
        out_q   <= result;
        out_vld <= 1'b1;
      end else if (output_V_write) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_1.sv
// Bench for bias_add_1: queue-backed FIFO sources, a frame-level reference
// model of the stream protocol, and integer-arithmetic expected results.
// Two instances share the stimulus: one without and one with ReLU.
module tb_bias_add_1;
  localparam int N_CH    = 4;
  localparam int N_PIX   = 2;
  localparam int ACC_W   = 32;
  localparam int COEFF_W = 16;
  localparam int DATA_W  = 16;
  localparam int SHIFT   = 8;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic [COEFF_W-1:0] bias_V_dout = '0;
  logic               bias_V_empty_n = 1'b0;
  logic [ACC_W-1:0]   input_V_dout = '0;
  logic               input_V_empty_n = 1'b0;
  logic               output_V_full_n = 1'b0;

  logic               bias_V_read,  bias_V_read_r;
  logic               input_V_read, input_V_read_r;
  logic [DATA_W-1:0]  output_V_din, output_V_din_r;
  logic               output_V_write, output_V_write_r;

  always #5 ap_clk = ~ap_clk;

  bias_add_1 #(.N_CH(N_CH), .N_PIX(N_PIX), .ACC_W(ACC_W), .COEFF_W(COEFF_W),
               .DATA_W(DATA_W), .SHIFT(SHIFT), .RELU(0)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
    .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
    .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write)
  );

  bias_add_1 #(.N_CH(N_CH), .N_PIX(N_PIX), .ACC_W(ACC_W), .COEFF_W(COEFF_W),
               .DATA_W(DATA_W), .SHIFT(SHIFT), .RELU(1)) dut_r (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read_r),
    .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read_r),
    .output_V_din(output_V_din_r), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write_r)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO contents offered to the DUT, and the reference model state.
  logic [COEFF_W-1:0] bq[$];
  logic [ACC_W-1:0]   iq[$];
  longint             expq[$];
  longint             expq_r[$];
  longint             bias_m[N_CH];
  int                 loaded;
  int                 in_cnt;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference result: (acc + bias) / 2^SHIFT rounded half up, then ReLU, then clip.
  function automatic longint ref_out(input longint acc, input longint b, input bit relu);
    longint s, r, den;
    den = longint'(1) << SHIFT;
    s = acc + b + den / 2;
    if (s >= 0) r = s / den;
    else        r = -((-s + den - 1) / den);
    if (relu && r < 0) r = 0;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    bq.delete(); iq.delete(); expq.delete(); expq_r.delete();
    loaded = 0;
    in_cnt = 0;
  endtask

  // One clock: present inputs, compare strobes/data mid-cycle, advance the model.
  task automatic step(input bit bg, input bit ig, input bit fn);
    bit exp_br, exp_ir, exp_wr;
    longint acc;
    bias_V_empty_n  = bg && (bq.size() > 0);
    bias_V_dout     = (bq.size() > 0) ? bq[0] : '0;
    input_V_empty_n = ig && (iq.size() > 0);
    input_V_dout    = (iq.size() > 0) ? iq[0] : '0;
    output_V_full_n = fn;
    @(negedge ap_clk);
    exp_br = (loaded < N_CH) && bias_V_empty_n;
    exp_ir = (loaded == N_CH) && input_V_empty_n && (expq.size() == 0 || fn);
    exp_wr = (expq.size() > 0) && fn;
    check("bias_read",  bias_V_read,  exp_br);
    check("input_read", input_V_read, exp_ir);
    check("write",      output_V_write, exp_wr);
    check("write_relu", output_V_write_r, exp_wr);
    check("input_read_relu", input_V_read_r, exp_ir);
    if (expq.size() > 0) begin
      check("din",      longint'($signed(output_V_din)),   expq[0]);
      check("din_relu", longint'($signed(output_V_din_r)), expq_r[0]);
    end
    if (exp_wr) begin
      void'(expq.pop_front());
      void'(expq_r.pop_front());
    end
    if (exp_br) begin
      bias_m[loaded] = longint'($signed(bq.pop_front()));
      loaded++;
    end
    if (exp_ir) begin
      acc = longint'($signed(iq.pop_front()));
      expq.push_back(ref_out(acc, bias_m[in_cnt % N_CH], 1'b0));
      expq_r.push_back(ref_out(acc, bias_m[in_cnt % N_CH], 1'b1));
      in_cnt++;
      if (in_cnt == N_CH * N_PIX) begin
        in_cnt = 0;
        loaded = 0;
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    bias_V_empty_n = 1'b0;
    input_V_empty_n = 1'b0;
    output_V_full_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    model_reset();
    @(negedge ap_clk);
    check("rst_bias_read",  bias_V_read,    0);
    check("rst_input_read", input_V_read,   0);
    check("rst_write",      output_V_write, 0);
    check("rst_din",        longint'(output_V_din), 0);
    @(posedge ap_clk);
    #1;
  endtask

  // Drain all queued traffic; rnd selects random gating of the handshakes.
  task automatic run_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((bq.size() > 0 || iq.size() > 0 || expq.size() > 0) && n < budget) begin
      if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      else     step(1'b1, 1'b1, 1'b1);
      n++;
    end
    check("drain_timeout", n >= budget, 0);
  endtask

  function automatic logic [ACC_W-1:0] rand_acc();
    case ($urandom_range(0, 3))
      0:       return ACC_W'($urandom);
      1:       return 32'h7FFF_0000 + ACC_W'($urandom_range(0, 32'hFFFF));
      2:       return 32'h8000_0000 + ACC_W'($urandom_range(0, 32'hFFFF));
      default: return ACC_W'(int'($urandom_range(0, 20000)) - 10000);
    endcase
  endfunction

  initial begin
    int n;
    logic [DATA_W-1:0] held;
    do_reset();

    // Frame 1: biases 10,-20,30,-40 offered every other cycle, acc = 256*k.
    bq.push_back(16'sd10); bq.push_back(-16'sd20); bq.push_back(16'sd30); bq.push_back(-16'sd40);
    for (int k = 0; k < 8; k++) iq.push_back(ACC_W'(256 * k));
    n = 0;
    while (loaded < N_CH && n < 40) begin
      step(n[0] == 1'b0, 1'b1, 1'b1);
      n++;
    end
    check("load_timeout", n >= 40, 0);
    run_idle(1'b0, 200);

    // Frame 2: biases 1..4, then 5 cycles of backpressure with a result pending.
    for (int k = 1; k <= 4; k++) bq.push_back(COEFF_W'(k));
    for (int k = 0; k < 8; k++) iq.push_back(rand_acc());
    n = 0;
    while (expq.size() == 0 && n < 40) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    check("bp_start_timeout", n >= 40, 0);
    step(1'b1, 1'b1, 1'b0);
    held = output_V_din;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("bp_hold", longint'(output_V_din), longint'(held));
    end
    run_idle(1'b0, 200);

    // Frame 3: zero bias, rounding and saturation corners.
    for (int k = 0; k < 4; k++) bq.push_back('0);
    iq.push_back(32'd128);        iq.push_back(-32'sd129);
    iq.push_back(32'h7FFF_FFFF);  iq.push_back(32'h8000_0000);
    iq.push_back(-32'sd129);      iq.push_back(32'd127);
    iq.push_back(-32'sd51200);    iq.push_back(-32'sd128);
    run_idle(1'b0, 200);

    // Randomised frames with random handshake gating.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) bq.push_back(COEFF_W'($urandom));
      for (int k = 0; k < 8; k++) iq.push_back(rand_acc());
    end
    run_idle(1'b1, 2000);

    // Reset at pix=1, ch=2, then a full reload is required before input flows.
    for (int k = 0; k < 4; k++) bq.push_back(COEFF_W'($urandom));
    for (int k = 0; k < 8; k++) iq.push_back(rand_acc());
    n = 0;
    while (!(loaded == N_CH && in_cnt == 6) && n < 100) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    check("midframe_timeout", n >= 100, 0);
    do_reset();
    for (int k = 0; k < 4; k++) bq.push_back(COEFF_W'($urandom));
    for (int k = 0; k < 8; k++) iq.push_back(rand_acc());
    n = 0;
    while (loaded < N_CH && n < 40) begin
      step(n[0] == 1'b0, 1'b1, 1'b1);
      n++;
    end
    check("reload_timeout", n >= 40, 0);
    run_idle(1'b1, 500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
